// File: rtl/adder_pkg.sv
// Shared constants for the pipelined adder/subtractor.
// Mode encodings used by the operand-prep logic.
package adder_pkg;
  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;
endpackage

// File: rtl/chunk_adder.sv
// Combinational CHUNK-bit ripple of full-adder cells.
// One instance per pipeline stage.
module chunk_adder #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co
);
  logic [CHUNK:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < CHUNK; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign co = c[CHUNK];
endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined two's-complement add/sub, one CHUNK-bit slice per stage.
// Valid/ready on both sides; whole pipe stalls when output is blocked.
module pipelined_addsub
  import adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             co,
  output logic             ovf
);
  localparam int STAGES = WIDTH / CHUNK;
  localparam int L      = STAGES - 1;

  logic             advance;
  logic [WIDTH-1:0] b_eff;
  logic             c0;

  logic [WIDTH-1:0] a_q [STAGES];
  logic [WIDTH-1:0] b_q [STAGES];
  logic [WIDTH-1:0] s_q [STAGES];
  logic             c_q [STAGES];
  logic             v_q [STAGES];

  logic [WIDTH-1:0] a_i [STAGES];
  logic [WIDTH-1:0] b_i [STAGES];
  logic [WIDTH-1:0] s_i [STAGES];
  logic [WIDTH-1:0] s_n [STAGES];
  logic             c_i [STAGES];
  logic             c_n [STAGES];
  logic             v_i [STAGES];

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  assign b_eff = (mode == MODE_SUB) ? ~b : b;
  assign c0    = (mode == MODE_SUB) ? 1'b1 : ci;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [CHUNK-1:0] slice;
    logic [WIDTH-1:0] nxt;

    if (k == 0) begin : g_head
      assign a_i[k] = a;
      assign b_i[k] = b_eff;
      assign c_i[k] = c0;
      assign s_i[k] = '0;
      assign v_i[k] = in_valid;
    end else begin : g_body
      assign a_i[k] = a_q[k-1];
      assign b_i[k] = b_q[k-1];
      assign c_i[k] = c_q[k-1];
      assign s_i[k] = s_q[k-1];
      assign v_i[k] = v_q[k-1];
    end

    chunk_adder #(.CHUNK(CHUNK)) u_add (
      .a  (a_i[k][k*CHUNK +: CHUNK]),
      .b  (b_i[k][k*CHUNK +: CHUNK]),
      .ci (c_i[k]),
      .s  (slice),
      .co (c_n[k])
    );

    // lower slices already summed ride along; this slice is spliced in
    always_comb begin
      nxt = s_i[k];
      nxt[k*CHUNK +: CHUNK] = slice;
    end

    assign s_n[k] = nxt;
  end

  // data regs load only on real beats so outputs hold across bubbles
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) begin
        v_q[i] <= 1'b0;
        c_q[i] <= 1'b0;
        a_q[i] <= '0;
        b_q[i] <= '0;
        s_q[i] <= '0;
      end
    end else if (advance) begin
      for (int i = 0; i < STAGES; i++) begin
        v_q[i] <= v_i[i];
        if (v_i[i]) begin
          a_q[i] <= a_i[i];
          b_q[i] <= b_i[i];
          s_q[i] <= s_n[i];
          c_q[i] <= c_n[i];
        end
      end
    end
  end

  assign out_valid = v_q[L];
  assign sum       = s_q[L];
  assign co        = c_q[L];
  assign ovf       = (a_q[L][WIDTH-1] == b_q[L][WIDTH-1])
                  && (s_q[L][WIDTH-1] != a_q[L][WIDTH-1]);
endmodule

// File: tb/tb_pipelined_addsub.sv
// Self-checking bench for pipelined_addsub (WIDTH=16, CHUNK=4).
// Directed spec cases plus randomized traffic against an arithmetic model.
module tb_pipelined_addsub;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        ci;
  logic        mode;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        co;
  logic        ovf;

  int vectors    = 0;
  int miscompares = 0;
  int accepted   = 0;
  int delivered  = 0;
  logic [17:0] expq [$];

  always #5 clk = ~clk;

  pipelined_addsub #(.WIDTH(16), .CHUNK(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .ci        (ci),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .co        (co),
    .ovf       (ovf)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input logic [31:0] obs, input logic [31:0] expv,
                     input string tag);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // {co, sum, ovf} from plain signed/unsigned arithmetic
  function automatic logic [17:0] model(input logic [15:0] ma,
                                        input logic [15:0] mb,
                                        input logic mci,
                                        input logic mmode);
    int   sa, sb, r, ua, ub;
    logic c, v;
    sa = int'($signed(ma));
    sb = int'($signed(mb));
    ua = int'(ma);
    ub = int'(mb);
    if (mmode) begin
      r = sa - sb;
      c = (ua >= ub);
    end else begin
      r = sa + sb + int'(mci);
      c = (ua + ub + int'(mci)) > 65535;
    end
    v = (r > 32767) || (r < -32768);
    return {c, r[15:0], v};
  endfunction

  task automatic cyc;
    @(posedge clk);
    @(negedge clk);
  endtask

  // bookkeeping of both handshakes for this cycle, then advance a cycle
  task automatic step;
    #1;
    if (in_valid && in_ready) begin
      expq.push_back(model(a, b, ci, mode));
      accepted++;
    end
    if (out_valid && out_ready) begin
      if (expq.size() == 0) begin
        chk(32'd1, 32'd0, "unexpected_result");
      end else begin
        chk({14'd0, co, sum, ovf}, {14'd0, expq.pop_front()}, "result");
      end
      delivered++;
    end
    cyc();
  endtask

  task automatic single(input logic [15:0] ta, input logic [15:0] tb2,
                        input logic tci, input logic tmode,
                        input logic [15:0] es, input logic eco,
                        input logic eovf, input string tag);
    int n;
    a = ta; b = tb2; ci = tci; mode = tmode;
    in_valid = 1'b1; out_ready = 1'b1;
    #1;
    chk({31'd0, in_ready}, 32'd1, {tag, "_in_ready"});
    cyc();
    in_valid = 1'b0;
    a = $urandom; b = $urandom; ci = $urandom; mode = $urandom;
    n = 1;
    while (!out_valid && n < 20) begin
      cyc();
      n++;
    end
    chk(n, 4, {tag, "_latency"});
    chk({16'd0, sum}, {16'd0, es}, {tag, "_sum"});
    chk({31'd0, co}, {31'd0, eco}, {tag, "_co"});
    chk({31'd0, ovf}, {31'd0, eovf}, {tag, "_ovf"});
    cyc();
  endtask

  initial begin
    logic [15:0] held;
    int          stalls;
    int          budget;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; ci = 1'b0; mode = 1'b0;

    // 1. reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk({31'd0, out_valid}, 32'd0, "rst_out_valid");
    chk({16'd0, sum}, 32'd0, "rst_sum");
    chk({31'd0, co}, 32'd0, "rst_co");
    chk({31'd0, ovf}, 32'd0, "rst_ovf");
    rst = 1'b0;
    #1;
    chk({31'd0, in_ready}, 32'd1, "rst_in_ready");
    @(negedge clk);

    // 2. add
    single(16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, "add1");
    single(16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, "add2");
    single(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, "add3");

    // 3. sub
    single(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, "sub1");
    single(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, "sub2");
    single(16'h1234, 16'h1234, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0, "sub3");

    // 4. back-to-back with a 3-cycle output stall on the 2nd result
    accepted = 0; delivered = 0; stalls = 0; held = '0;
    expq.delete();
    budget = 0;
    while (delivered < 8 && budget < 60) begin
      in_valid = (accepted < 8);
      a = $urandom; b = $urandom; ci = $urandom; mode = $urandom;
      out_ready = 1'b1;
      if (delivered == 1 && out_valid && stalls < 3) begin
        out_ready = 1'b0;
        if (stalls == 0) held = sum;
        stalls++;
        #1;
        chk({31'd0, in_ready}, 32'd0, "stall_in_ready");
        chk({16'd0, sum}, {16'd0, held}, "stall_sum_held");
      end
      step();
      budget++;
    end
    chk(delivered, 8, "b2b_delivered");
    chk(expq.size(), 0, "b2b_queue_empty");
    chk(stalls, 3, "b2b_stalls");
    in_valid = 1'b0;
    repeat (3) begin
      #1;
      chk({31'd0, out_valid}, 32'd0, "b2b_no_extra");
      cyc();
    end

    // 5. reset mid-flight
    expq.delete();
    accepted = 0;
    out_ready = 1'b1;
    repeat (3) begin
      in_valid = 1'b1;
      a = $urandom; b = $urandom; ci = $urandom; mode = $urandom;
      step();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    cyc();
    chk({31'd0, out_valid}, 32'd0, "midrst_out_valid");
    chk({16'd0, sum}, 32'd0, "midrst_sum");
    rst = 1'b0;
    expq.delete();
    repeat (8) begin
      #1;
      chk({31'd0, out_valid}, 32'd0, "midrst_no_stale");
      cyc();
    end

    // 6. random traffic
    accepted = 0; delivered = 0;
    expq.delete();
    for (int i = 0; i < 10000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 7))
        0: begin a = 16'hFFFF; b = $urandom; end
        1: begin a = 16'h8000; b = 16'h7FFF; end
        2: begin a = $urandom; b = a; end
        default: begin a = $urandom; b = $urandom; end
      endcase
      ci   = $urandom;
      mode = $urandom;
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    budget = 0;
    while (expq.size() != 0 && budget < 100) begin
      step();
      budget++;
    end
    chk(expq.size(), 0, "rand_drained");
    chk(delivered, accepted, "rand_count");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
